vga_frame_fetch: RTL and testbench
==================================

# vga_frame_fetch

Framebuffer fetch stage feeding the VGA pixel path. Reads a 160x120 RGB332 framebuffer from the second (read) port of the data RAM during horizontal blanking, holds one source row in an internal line buffer, and emits 8-bit r/g/b for the 640x480 display at 4x scaling in both directions. Sits between `vgaController` (x/y source) and the video DAC outputs, replacing the fixed-pattern generator when the processor draws into memory.

## Interface
- `FB_BASE`, 0: word address of framebuffer row 0, word 0
- `ADDR_W`, 13: RAM word-address width
- `MEM_LAT`, 1: cycles from `mem_rd_en`/`mem_addr` to valid `mem_rdata` (1..3)
- `clk` input 1: pixel clock (25.175 MHz `vgaclk`); RAM read port is clocked by the same clock
- `rst` input 1: synchronous, active-high reset
- `x` input 10: current horizontal counter from `vgaController`, 0..799
- `y` input 10: current vertical counter, 0..524
- `mem_addr` output ADDR_W: RAM read word address
- `mem_rd_en` output 1: read strobe, one word per asserted cycle
- `mem_rdata` input 32: read data, valid MEM_LAT cycles after strobe
- `r`, `g`, `b` output 8 each: pixel colour, registered
- `fetch_busy` output 1: fetch FSM not idle
- `overrun` output 1: sticky, a fetch trigger arrived while busy

## Operation
- Framebuffer layout: row-major, 40 words per source row, row `s` starts at `FB_BASE + s*40` (computed as `(s<<5)+(s<<3)`, truncated to ADDR_W). Byte 0 (bits 7:0) is the leftmost pixel of a word.
- Line buffer: 40 x 32-bit registers plus `buf_valid` flag.
- Fetch trigger (single cycle): `x==640` and (`y==524`, source row 0) or (`y<479` and `y[1:0]==3`, source row `(y+1)>>2`). No trigger on `y==479`.
- FSM states:
  - IDLE: on trigger latch source row, clear word counter, go ISSUE.
  - ISSUE: assert `mem_rd_en`, `mem_addr = row_base + wcnt`, increment `wcnt`; after `wcnt==39` go DRAIN.
  - DRAIN: wait until the last in-flight word is written, set `buf_valid`, go IDLE.
- Capture: a MEM_LAT-deep shift register carries {valid, word index}; when its output is valid, `mem_rdata` is written to the line buffer at that index.
- Trigger while not IDLE: ignored, `overrun` set to 1 until reset.
- Pixel select: word `x[9:4]`, byte `x[3:2]`; p = selected byte.
- Colour expansion: `r={p[7:5],p[7:5],p[7:6]}`, `g={p[4:2],p[4:2],p[4:3]}`, `b={p[1:0],p[1:0],p[1:0],p[1:0]}`.
- Outside active area (`x>=640` or `y>=480`) or `buf_valid==0`: r=g=b=0.

## Timing
- Reset values: r=g=b=0, `mem_rd_en`=0, `mem_addr`=0, `fetch_busy`=0, `overrun`=0, `buf_valid`=0. FSM returns to IDLE and the capture pipe is cleared. Line-buffer contents are not reset.
- Reset mid-fetch: in-flight reads are discarded. Output stays black until the next complete fetch.
- Fetch length: 40 issue cycles plus MEM_LAT drain cycles.
- `mem_rd_en` is high on x=641..680 of the trigger line, with `fetch_busy` high from x=641.
- The fetch completes by x = 681+MEM_LAT, which is well before x=799. The new row is therefore visible from x=0 of the next line.
- Pixel latency is 1 cycle: r/g/b at cycle t+1 correspond to x/y at cycle t. The integrating top delays `hsync`/`vsync`/`blank_b` by one cycle to match.
- The line buffer is never written while `x<640`, so no tearing occurs within a line.

## Test plan
- Reset, then a frame with RAM word `FB_BASE`=0x000000E0 (byte0=0xE0): x=0..3, y=0 -> r=0xFF, g=0, b=0 (one cycle late); x=4..7 -> black.
- Row addressing, FB_BASE=0x100: trigger at x=640, y=7 -> `mem_addr` sweeps 0x150..0x177 (row 2), `mem_rd_en` high exactly 40 cycles; `fetch_busy` drops at x=681+MEM_LAT.
- Scaling: distinct byte per source pixel -> each byte appears on 4 consecutive x and 4 consecutive y. No fetch on y=479; row 0 is fetched on y=524.
- Blanking: any x>=640 or y>=480 -> r=g=b=0 regardless of buffer contents.
- Overrun: force a second trigger (drive x=640 twice within 40 cycles) -> `overrun`=1 and stays 1; the first fetch still completes all 40 words.
- Reset at wcnt=20 -> `mem_rd_en`=0 next cycle, `buf_valid`=0, output black until the next full fetch; repeat the test with MEM_LAT=1,2,3.

Source files
------------

// File: rtl/vga_frame_fetch.sv
// Framebuffer fetch stage: pulls one 160-pixel RGB332 source row into a line buffer
// during horizontal blanking and expands it 4x in both directions onto the 640x480 raster.
module vga_frame_fetch #(
    parameter int FB_BASE = 0,
    parameter int ADDR_W  = 13,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              fetch_busy,
    output logic              overrun
);

    localparam int WORDS = 40;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        wcnt_q, wcnt_d;
    logic [6:0]        row_q, row_d;
    logic              buf_valid_q, buf_valid_d;
    logic              overrun_q, overrun_d;

    logic [MEM_LAT-1:0] cap_vld_q;
    logic [5:0]         cap_idx_q [MEM_LAT];
    logic [31:0]        line_buf_q [WORDS];

    logic               trigger;
    logic [6:0]         trig_row;
    logic [ADDR_W-1:0]  row_base;
    logic               cap_vld;
    logic [5:0]         cap_idx;

    logic [5:0]         word_idx;
    logic [31:0]        sel_word;
    logic [7:0]         pix;
    logic               active;
    logic [7:0]         r_q, g_q, b_q;

    // Fetch the source row needed by the *next* display line; y==524 primes row 0.
    assign trigger  = (x == 10'd640) &&
                      ((y == 10'd524) || ((y < 10'd479) && (y[1:0] == 2'b11)));
    assign trig_row = (y == 10'd524) ? 7'd0 : 7'((y + 10'd1) >> 2);
    assign row_base = ADDR_W'(FB_BASE) + (ADDR_W'(row_q) << 5) + (ADDR_W'(row_q) << 3);

    assign cap_vld  = cap_vld_q[MEM_LAT-1];
    assign cap_idx  = cap_idx_q[MEM_LAT-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        row_d       = row_q;
        buf_valid_d = buf_valid_q;
        overrun_d   = overrun_q;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;

        if (trigger && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    row_d   = trig_row;
                    wcnt_d  = 6'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_en = 1'b1;
                mem_addr  = row_base + ADDR_W'(wcnt_q);
                wcnt_d    = wcnt_q + 6'd1;
                if (wcnt_q == 6'(WORDS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_vld && (cap_idx == 6'(WORDS - 1))) begin
                    buf_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 6'd0;
            row_q       <= 7'd0;
            buf_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            row_q       <= row_d;
            buf_valid_q <= buf_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Read-return tracker: {valid, word index} delayed to line up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                cap_idx_q[i] <= 6'd0;
            end
        end else begin
            cap_vld_q[0] <= mem_rd_en;
            cap_idx_q[0] <= wcnt_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                cap_vld_q[i] <= cap_vld_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
        end
    end

    // NOTE: the line buffer has no reset; buf_valid gates its use, so stale contents never reach the DAC.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            line_buf_q[cap_idx] <= mem_rdata;
        end
    end

    always_comb begin
        word_idx = x[9:4];
        sel_word = (word_idx < 6'(WORDS)) ? line_buf_q[word_idx] : 32'd0;
        pix      = sel_word[{x[3:2], 3'b000} +: 8];
        active   = (x < 10'd640) && (y < 10'd480) && buf_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'd0;
            g_q <= 8'd0;
            b_q <= 8'd0;
        end else if (active) begin
            r_q <= {pix[7:5], pix[7:5], pix[7:6]};
            g_q <= {pix[4:2], pix[4:2], pix[4:3]};
            b_q <= {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
        end else begin
            r_q <= 8'd0;
            g_q <= 8'd0;
            b_q <= 8'd0;
        end
    end

    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign fetch_busy = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch: three instances (MEM_LAT 1..3) share x/y and a
// framebuffer image; each has its own latency-matched RAM read port.
module tb_vga_frame_fetch;

    localparam int N    = 3;
    localparam int AW   = 13;
    localparam int BASE = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x   = 10'd0;
    logic [9:0]  y   = 10'd0;

    logic [AW-1:0] addr_w  [N];
    logic          rd_en_w [N];
    logic [31:0]   rdata_w [N];
    logic [7:0]    r_w     [N];
    logic [7:0]    g_w     [N];
    logic [7:0]    b_w     [N];
    logic          busy_w  [N];
    logic          ovr_w   [N];

    logic [31:0] mem [0:8191];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int L = k + 1;
        logic [31:0] rd_pipe [L];

        vga_frame_fetch #(
            .FB_BASE(BASE),
            .ADDR_W (AW),
            .MEM_LAT(L)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .x         (x),
            .y         (y),
            .mem_addr  (addr_w[k]),
            .mem_rd_en (rd_en_w[k]),
            .mem_rdata (rdata_w[k]),
            .r         (r_w[k]),
            .g         (g_w[k]),
            .b         (b_w[k]),
            .fetch_busy(busy_w[k]),
            .overrun   (ovr_w[k])
        );

        always @(posedge clk) begin
            rd_pipe[0] <= mem[addr_w[k]];
            for (int i = 1; i < L; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
        assign rdata_w[k] = rd_pipe[L-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel position and check the registered colour one cycle later.
    task automatic pix(input int yv, input int xv, input logic [23:0] exp);
        y = 10'(yv);
        x = 10'(xv);
        tick();
        for (int k = 0; k < N; k++) begin
            check($sformatf("rgb y%0d x%0d lat%0d", yv, xv, k + 1),
                  {8'd0, r_w[k], g_w[k], b_w[k]}, {8'd0, exp});
        end
    endtask

    task automatic check_ctrl(input string tag, input logic rd, input logic bsy, input logic ovr);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s rd_en lat%0d", tag, k + 1), 32'(rd_en_w[k]), 32'(rd));
            check($sformatf("%s busy lat%0d", tag, k + 1), 32'(busy_w[k]), 32'(bsy));
            check($sformatf("%s overrun lat%0d", tag, k + 1), 32'(ovr_w[k]), 32'(ovr));
        end
    endtask

    // Trigger at x=640 of line yv, sweep x=641..720, check address sweep and timing.
    task automatic do_fetch(input int yv, input int base);
        int cnt      [N];
        int first_rd [N];
        int busy_end [N];
        for (int k = 0; k < N; k++) begin
            cnt[k]      = 0;
            first_rd[k] = -1;
            busy_end[k] = -1;
        end
        y = 10'(yv);
        x = 10'd640;
        tick();
        for (int xv = 641; xv <= 720; xv++) begin
            x = 10'(xv);
            for (int k = 0; k < N; k++) begin
                if (rd_en_w[k]) begin
                    if (first_rd[k] < 0) first_rd[k] = xv;
                    check($sformatf("addr y%0d w%0d lat%0d", yv, cnt[k], k + 1),
                          32'(addr_w[k]), 32'(base + cnt[k]));
                    cnt[k]++;
                end
                if (!busy_w[k] && (busy_end[k] < 0)) busy_end[k] = xv;
            end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("rd count y%0d lat%0d", yv, k + 1), 32'(cnt[k]), 32'd40);
            check($sformatf("first rd x y%0d lat%0d", yv, k + 1), 32'(first_rd[k]), 32'd641);
            check($sformatf("busy drop x y%0d lat%0d", yv, k + 1), 32'(busy_end[k]), 32'(682 + k));
        end
    endtask

    initial begin
        int cnt [N];
        logic [23:0] row0_exp [4];

        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        mem[BASE + 0]        = 32'h031C00E0;   // row 0: red, black, green, blue
        mem[BASE + 20]       = 32'h00FF0000;
        mem[BASE + 39]       = 32'h6D000092;
        mem[BASE + 40]       = 32'h00000049;   // row 1
        mem[BASE + 80]       = 32'h000000B5;   // row 2
        mem[BASE + 120]      = 32'h0000001C;   // row 3
        mem[BASE + 120 + 39] = 32'h03000000;
        mem[BASE + 160]      = 32'h000000E0;   // row 4

        row0_exp[0] = 24'hFF0000;
        row0_exp[1] = 24'h000000;
        row0_exp[2] = 24'h00FF00;
        row0_exp[3] = 24'h0000FF;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset rgb lat%0d", k + 1), {8'd0, r_w[k], g_w[k], b_w[k]}, 32'd0);
            check($sformatf("reset addr lat%0d", k + 1), 32'(addr_w[k]), 32'd0);
        end
        rst = 1'b0;
        pix(0, 0, 24'h000000);

        // Row 0 fetched on the last line of the frame, then shown 4x in x and y
        do_fetch(524, BASE);
        for (int xv = 0; xv < 16; xv++) pix(0, xv, row0_exp[xv / 4]);
        pix(0, 330, 24'hFFFFFF);
        pix(0, 624, 24'h9292AA);
        pix(0, 627, 24'h9292AA);
        pix(0, 636, 24'h6D6D55);
        pix(0, 639, 24'h6D6D55);
        pix(3, 2, 24'hFF0000);

        // Blanking
        pix(2, 640, 24'h000000);
        pix(2, 700, 24'h000000);
        pix(480, 0, 24'h000000);
        pix(500, 12, 24'h000000);
        pix(1, 1, 24'hFF0000);

        // Rows 1 and 2
        do_fetch(3, BASE + 40);
        pix(4, 0, 24'h494955);
        pix(5, 3, 24'h494955);
        do_fetch(7, BASE + 80);
        pix(8, 0, 24'hB6B655);

        // No fetch on y=479 or on a line with y[1:0]!=3
        y = 10'd479; x = 10'd640; tick();
        x = 10'd641;
        check_ctrl("no trig y479", 1'b0, 1'b0, 1'b0);
        y = 10'd478; x = 10'd640; tick();
        x = 10'd641;
        check_ctrl("no trig y478", 1'b0, 1'b0, 1'b0);
        pix(8, 0, 24'hB6B655);

        // Last source row: base + 119*40
        do_fetch(475, BASE + 4760);

        // Overrun: second trigger mid-fetch is ignored, first fetch completes
        for (int k = 0; k < N; k++) cnt[k] = 0;
        y = 10'd11; x = 10'd640; tick();
        for (int xv = 641; xv <= 650; xv++) begin
            x = 10'(xv);
            for (int k = 0; k < N; k++) if (rd_en_w[k]) cnt[k]++;
            tick();
        end
        for (int k = 0; k < N; k++) check($sformatf("ovr pre lat%0d", k + 1), 32'(ovr_w[k]), 32'd0);
        x = 10'd640;
        for (int k = 0; k < N; k++) if (rd_en_w[k]) cnt[k]++;
        tick();
        for (int k = 0; k < N; k++) check($sformatf("ovr set lat%0d", k + 1), 32'(ovr_w[k]), 32'd1);
        for (int xv = 651; xv <= 720; xv++) begin
            x = 10'(xv);
            for (int k = 0; k < N; k++) if (rd_en_w[k]) cnt[k]++;
            tick();
        end
        for (int k = 0; k < N; k++) check($sformatf("ovr rd count lat%0d", k + 1), 32'(cnt[k]), 32'd40);
        check_ctrl("ovr end", 1'b0, 1'b0, 1'b1);
        pix(12, 0, 24'h00FF00);
        pix(12, 636, 24'h0000FF);
        check_ctrl("ovr sticky", 1'b0, 1'b0, 1'b1);

        // Reset at wcnt=20: reads stop, buffer invalid until the next full fetch
        y = 10'd15; x = 10'd640; tick();
        for (int xv = 641; xv <= 660; xv++) begin
            x = 10'(xv);
            tick();
        end
        rst = 1'b1;
        x = 10'd661;
        tick();
        rst = 1'b0;
        check_ctrl("mid reset", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int xv = 662; xv <= 720; xv++) begin
            x = 10'(xv);
            for (int k = 0; k < N; k++) if (rd_en_w[k]) cnt[k]++;
            tick();
        end
        for (int k = 0; k < N; k++) check($sformatf("post reset rd lat%0d", k + 1), 32'(cnt[k]), 32'd0);
        pix(16, 0, 24'h000000);
        pix(16, 636, 24'h000000);
        do_fetch(15, BASE + 160);
        pix(16, 0, 24'hFF0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
